// File: rtl/ts_sync_align_8bit_if.sv
// Byte-stream bundle between the serialiser, the TS aligner and the TS split logic.
// master drives the raw byte stream and receives the aligned stream; slave is the aligner.
interface ts_sync_align_8bit_if;
  logic [7:0] din_8bit;
  logic       din_8bit_en;
  logic [7:0] dout_8bit;
  logic       dout_8bit_en;
  logic       dout_sop;
  logic       dout_eop;
  logic       sync_locked;

  modport master (
    output din_8bit, din_8bit_en,
    input  dout_8bit, dout_8bit_en, dout_sop, dout_eop, sync_locked
  );

  modport slave (
    input  din_8bit, din_8bit_en,
    output dout_8bit, dout_8bit_en, dout_sop, dout_eop, sync_locked
  );
endinterface

// File: rtl/ts_sync_align_8bit.sv
// MPEG-TS packet aligner: hunts for SYNC_BYTE, verifies the packet period, then forwards whole packets.
// Optional TS_ERR_FLAG_EN: sets transport_error_indicator on packets with a tolerated bad sync byte.
module ts_sync_align_8bit #(
  parameter logic [7:0] SYNC_BYTE  = 8'h47,
  parameter int         PKT_LEN    = 188,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  ts_sync_align_8bit_if.slave   bus
);

  localparam int IW = $clog2(PKT_LEN);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] byte_idx, idx_nxt, idx_inc;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [MW-1:0] miss_cnt, miss_nxt;
  logic          boundary, is_sync;
  logic          out_en, out_sop, out_eop;
  logic [7:0]    out_byte;
  logic [7:0]    dout_q;
  logic          dout_en_q, dout_sop_q, dout_eop_q;
`ifdef TS_ERR_FLAG_EN
  logic          err_pkt, err_nxt;
`endif

  assign boundary = (byte_idx == '0);
  assign is_sync  = (bus.din_8bit == SYNC_BYTE);
  assign idx_inc  = (byte_idx == LAST_IDX) ? '0 : byte_idx + IW'(1);

  always_comb begin
    state_nxt = state;
    idx_nxt   = byte_idx;
    good_nxt  = good_cnt;
    miss_nxt  = miss_cnt;
    out_en    = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_byte  = bus.din_8bit;
`ifdef TS_ERR_FLAG_EN
    err_nxt   = err_pkt;
`endif
    if (bus.din_8bit_en) begin
      unique case (state)
        HUNT: begin
          if (is_sync) begin
            idx_nxt  = IW'(1);
            good_nxt = GW'(1);
            if (LOCK_CNT == 1) begin
              state_nxt = LOCKED;
              out_en    = 1'b1;
              out_sop   = 1'b1;
            end else begin
              state_nxt = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (!boundary) begin
            idx_nxt = idx_inc;
          end else if (is_sync) begin
            idx_nxt  = idx_inc;
            good_nxt = good_cnt + GW'(1);
            if (int'(good_cnt) + 1 == LOCK_CNT) begin
              state_nxt = LOCKED;
              out_en    = 1'b1;
              out_sop   = 1'b1;
            end
          end else begin
            // failing boundary byte is not a sync, so hunting resumes on the next byte
            state_nxt = HUNT;
            idx_nxt   = '0;
            good_nxt  = '0;
          end
        end
        LOCKED: begin
          idx_nxt = idx_inc;
          out_en  = 1'b1;
          out_sop = boundary;
          out_eop = (byte_idx == LAST_IDX);
          if (boundary) begin
            if (is_sync) begin
              miss_nxt = '0;
`ifdef TS_ERR_FLAG_EN
              err_nxt  = 1'b0;
`endif
            end else if (int'(miss_cnt) + 1 == UNLOCK_CNT) begin
              // drop the byte so output always ends on an eop
              state_nxt = HUNT;
              idx_nxt   = '0;
              good_nxt  = '0;
              miss_nxt  = '0;
              out_en    = 1'b0;
              out_sop   = 1'b0;
              out_eop   = 1'b0;
`ifdef TS_ERR_FLAG_EN
              err_nxt   = 1'b0;
`endif
            end else begin
              miss_nxt = miss_cnt + MW'(1);
`ifdef TS_ERR_FLAG_EN
              err_nxt  = 1'b1;
`endif
            end
          end
`ifdef TS_ERR_FLAG_EN
          if (err_pkt && byte_idx == IW'(1)) out_byte[7] = 1'b1;
`endif
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= HUNT;
      byte_idx   <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
`ifdef TS_ERR_FLAG_EN
      err_pkt    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      byte_idx   <= idx_nxt;
      good_cnt   <= good_nxt;
      miss_cnt   <= miss_nxt;
      dout_en_q  <= out_en;
      dout_sop_q <= out_sop;
      dout_eop_q <= out_eop;
      if (out_en) dout_q <= out_byte;
`ifdef TS_ERR_FLAG_EN
      err_pkt    <= err_nxt;
`endif
    end
  end

  assign bus.dout_8bit    = dout_q;
  assign bus.dout_8bit_en = dout_en_q;
  assign bus.dout_sop     = dout_sop_q;
  assign bus.dout_eop     = dout_eop_q;
  assign bus.sync_locked  = (state == LOCKED);

endmodule
